dt_sched: RTL and testbench

DT_SCHED -- requirements
Module: dt_sched

---
 rtl/dt_sched.sv | 121 ++++++++++++
 tb/tb_dt_sched.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/dt_sched.sv
// Emulated-time step scheduler: issues the minimum requested timestep each cycle,
// clamps it to a stop-time breakpoint, and accumulates emulated time.

module dt_sched_lane #(
    parameter int DT_WIDTH = 32
) (
    input  logic                en,
    input  logic [DT_WIDTH-1:0] dt,
    input  logic [DT_WIDTH-1:0] step,
    output logic [DT_WIDTH-1:0] cand,
    output logic                hit
);
    // A disabled requester contributes all-ones, which never lowers the minimum.
    assign cand = en ? dt : '1;
    assign hit  = en && (dt == step);
endmodule

module dt_sched #(
    parameter int N_REQ      = 4,
    parameter int DT_WIDTH   = 32,
    parameter int TIME_WIDTH = 64
) (
    input  logic                      emu_clk,
    input  logic                      emu_rst,
    input  logic [N_REQ*DT_WIDTH-1:0] dt_req,
    input  logic [N_REQ-1:0]          req_en,
    input  logic [DT_WIDTH-1:0]       ext_dt,
    input  logic                      ext_dt_en,
    input  logic                      run_en,
    input  logic                      stop_en,
    input  logic [TIME_WIDTH-1:0]     stop_time,
    input  logic                      clr_time,
    output logic [DT_WIDTH-1:0]       emu_dt,
    output logic [N_REQ-1:0]          grant,
    output logic [TIME_WIDTH-1:0]     emu_time,
    output logic [1:0]                state
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] HALT = 2'd2;

    logic [N_REQ-1:0][DT_WIDTH-1:0] req_v;
    logic [N_REQ-1:0][DT_WIDTH-1:0] cand;
    logic [N_REQ-1:0]               hit;
    logic [DT_WIDTH-1:0]            dt_min;
    logic [DT_WIDTH-1:0]            step;
    logic [DT_WIDTH-1:0]            remain_dt;
    logic [TIME_WIDTH:0]            reach;
    logic                           issue;
    logic                           bp_hit;
    logic                           past_stop;
    logic [1:0]                     nxt;

    assign req_v = dt_req;

    genvar g;
    generate
        for (g = 0; g < N_REQ; g++) begin : g_lane
            dt_sched_lane #(.DT_WIDTH(DT_WIDTH)) u_lane (
                .en   (req_en[g]),
                .dt   (req_v[g]),
                .step (step),
                .cand (cand[g]),
                .hit  (hit[g])
            );
        end
    endgenerate

    always_comb begin
        dt_min = '1;
        if (ext_dt_en && ext_dt < dt_min) dt_min = ext_dt;
        for (int i = 0; i < N_REQ; i++)
            if (cand[i] < dt_min) dt_min = cand[i];
    end

    // One extra bit so the breakpoint compare cannot be fooled by wrap-around.
    assign reach     = {1'b0, emu_time} + (TIME_WIDTH+1)'(dt_min);
    assign bp_hit    = stop_en && (reach >= {1'b0, stop_time});
    assign past_stop = stop_time <= emu_time;
    assign remain_dt = DT_WIDTH'(stop_time - emu_time);

    // Steps are only issued from RUN while run is still requested; the edge
    // leaving IDLE issues nothing, so the first step appears one cycle later.
    assign issue = (state == RUN) && run_en;

    always_comb begin
        step = '0;
        if (issue) begin
            if (!bp_hit)        step = dt_min;
            else if (!past_stop) step = remain_dt;
        end
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE: if (run_en && !(stop_en && past_stop)) nxt = RUN;
            RUN: begin
                if (!run_en)     nxt = IDLE;
                else if (bp_hit) nxt = HALT;
            end
            HALT: if (!run_en) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge emu_clk or posedge emu_rst) begin
        if (emu_rst) begin
            state    <= IDLE;
            emu_dt   <= '0;
            grant    <= '0;
            emu_time <= '0;
        end else begin
            state  <= nxt;
            emu_dt <= step;
            grant  <= issue ? hit : '0;
            if (state != RUN && clr_time) emu_time <= '0;
            else                          emu_time <= emu_time + TIME_WIDTH'(step);
        end
    end
endmodule

// File: tb/tb_dt_sched.sv
// Directed scoreboard bench for dt_sched: stimulus pushes hand-computed
// post-edge expectations, a monitor pops and compares after every rising edge.

module tb_dt_sched;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int TW = 64;

    logic              emu_clk = 0;
    logic              emu_rst = 1;
    logic [N*DW-1:0]   dt_req = '0;
    logic [N-1:0]      req_en = '0;
    logic [DW-1:0]     ext_dt = '0;
    logic              ext_dt_en = 0;
    logic              run_en = 0;
    logic              stop_en = 0;
    logic [TW-1:0]     stop_time = '0;
    logic              clr_time = 0;
    logic [DW-1:0]     emu_dt;
    logic [N-1:0]      grant;
    logic [TW-1:0]     emu_time;
    logic [1:0]        state;

    dt_sched #(.N_REQ(N), .DT_WIDTH(DW), .TIME_WIDTH(TW)) dut (
        .emu_clk(emu_clk), .emu_rst(emu_rst), .dt_req(dt_req), .req_en(req_en),
        .ext_dt(ext_dt), .ext_dt_en(ext_dt_en), .run_en(run_en), .stop_en(stop_en),
        .stop_time(stop_time), .clr_time(clr_time), .emu_dt(emu_dt), .grant(grant),
        .emu_time(emu_time), .state(state)
    );

    always #5 emu_clk = ~emu_clk;

    typedef struct {
        logic [1:0]    st;
        logic [DW-1:0] dt;
        logic [N-1:0]  gr;
        logic [TW-1:0] tm;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc_no = 0;

    task automatic chk(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %0d expected %0d", name, cyc_no, act, exp);
        end
    endtask

    // Monitor: outputs settle right after each rising edge.
    always @(posedge emu_clk) begin
        exp_t e;
        cyc_no++;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("state",    TW'(state),  TW'(e.st));
            chk("emu_dt",   TW'(emu_dt), TW'(e.dt));
            chk("grant",    TW'(grant),  TW'(e.gr));
            chk("emu_time", emu_time,    e.tm);
        end
    end

    // Inputs already set for this cycle; queue what the next edge must produce.
    task automatic cyc(input logic [1:0] st, input logic [DW-1:0] dt,
                       input logic [N-1:0] gr, input logic [TW-1:0] tm);
        exp_t e;
        e.st = st; e.dt = dt; e.gr = gr; e.tm = tm;
        q.push_back(e);
        @(negedge emu_clk);
    endtask

    task automatic set_req(input logic [DW-1:0] r3, input logic [DW-1:0] r2,
                           input logic [DW-1:0] r1, input logic [DW-1:0] r0);
        dt_req = {r3, r2, r1, r0};
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_state"}, TW'(state), 0);
        chk({tag, "_dt"},    TW'(emu_dt), 0);
        chk({tag, "_grant"}, TW'(grant), 0);
        chk({tag, "_time"},  emu_time, 0);
    endtask

    localparam logic [1:0] I = 2'd0, R = 2'd1, H = 2'd2;

    initial begin
        repeat (2) @(negedge emu_clk);
        chk_zero("reset");
        emu_rst = 0;

        // Minimum with a tie
        req_en = 4'b1111; set_req(400, 250, 250, 900); run_en = 1;
        cyc(R, 0, 0, 0);
        cyc(R, 250, 4'b0110, 250);
        cyc(R, 250, 4'b0110, 500);
        cyc(R, 250, 4'b0110, 750);

        // Pause and resume without losing time
        run_en = 0;
        cyc(I, 0, 0, 750);
        cyc(I, 0, 0, 750);
        run_en = 1;
        cyc(R, 0, 0, 750);
        cyc(R, 250, 4'b0110, 1000);

        // External cap below every request; clr_time ignored in RUN
        ext_dt_en = 1; ext_dt = 100; clr_time = 1;
        cyc(R, 100, 0, 1100);
        clr_time = 0;
        cyc(R, 100, 0, 1200);

        // Empty candidate set gives all-ones
        req_en = 0; ext_dt_en = 0;
        cyc(R, 32'hFFFF_FFFF, 0, 64'd4294968495);
        run_en = 0;
        cyc(I, 0, 0, 64'd4294968495);

        // clr_time in IDLE
        clr_time = 1;
        cyc(I, 0, 0, 0);
        clr_time = 0;

        // Breakpoint: 300,300,300 then clamped 100 into HALT
        req_en = 4'b0001; set_req(0, 0, 0, 300);
        stop_en = 1; stop_time = 1000; run_en = 1;
        cyc(R, 0, 0, 0);
        cyc(R, 300, 4'b0001, 300);
        cyc(R, 300, 4'b0001, 600);
        cyc(R, 300, 4'b0001, 900);
        cyc(H, 100, 0, 1000);
        cyc(H, 0, 0, 1000);

        // clr_time in HALT clears; HALT persists while run_en=1
        clr_time = 1;
        cyc(H, 0, 0, 0);
        clr_time = 0;
        run_en = 0;
        cyc(I, 0, 0, 0);

        // stop_time moved below emu_time mid-RUN
        stop_en = 0; run_en = 1;
        cyc(R, 0, 0, 0);
        cyc(R, 300, 4'b0001, 300);
        stop_en = 1; stop_time = 200;
        cyc(H, 0, 0, 300);
        run_en = 0;
        cyc(I, 0, 0, 300);
        run_en = 1;
        cyc(I, 0, 0, 300);   // already past the breakpoint: stay IDLE

        // Zero step is legal, grants the zero requesters, time holds
        stop_en = 0; req_en = 4'b0011; set_req(0, 0, 0, 0);
        cyc(R, 0, 0, 300);
        cyc(R, 0, 4'b0011, 300);

        // Step lands exactly on stop_time: unclamped value, grant kept
        stop_en = 1; stop_time = 800; set_req(0, 0, 500, 500);
        cyc(H, 500, 4'b0011, 800);
        run_en = 0;
        cyc(I, 0, 0, 800);

        // run_en drop wins over a simultaneous clamp
        stop_en = 0; run_en = 1; req_en = 4'b0001;
        cyc(R, 0, 0, 800);
        stop_en = 1; stop_time = 900; run_en = 0;
        cyc(I, 0, 0, 800);

        // Async reset mid-RUN
        stop_en = 0; run_en = 1;
        cyc(R, 0, 0, 800);
        cyc(R, 500, 4'b0001, 1300);
        #3;
        emu_rst = 1;
        #1;
        chk_zero("async_rst");
        @(negedge emu_clk);
        chk_zero("rst_hold");
        emu_rst = 0;
        cyc(R, 0, 0, 0);
        cyc(R, 500, 4'b0001, 500);

        @(negedge emu_clk);
        chk("queue_drained", TW'(q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
